reset_gen: RTL and testbench



---
 rtl/reset_gen.sv | 94 +++++++++
 tb/tb_reset_gen.sv | 138 +++++++++++++
 2 files changed

// File: rtl/reset_gen.sv
`timescale 1ns/1ps
// reset_gen: stretched active-low system reset after an FPGA start or a press of button 1.
// Define RESET_BUTTON_EN to build the button synchronizer and the button-triggered reset.
module reset_gen #(
  parameter int unsigned RESET_CYCLES = 4_800_000,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic fpga_start,
  input  logic fpga_but1,
  output logic reset,
  output logic fsm_state
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [23:0] RELOAD = 24'(RESET_CYCLES - 1);

  // Declaration values are the bitstream power-up contents: RUN, idle counter, reset released.
  state_t      state   = RUN;
  logic [23:0] cnt     = '0;
  logic        reset_q = 1'b1;

  state_t      state_next;
  logic [23:0] cnt_next;
  logic        reset_next;
  logic        pressed;

`ifdef RESET_BUTTON_EN
  // Button path: all stages preset to released so a start never reads as a press.
  logic [SYNC_STAGES-1:0] sync = '1;

  always_ff @(posedge clk or negedge fpga_start) begin
    if (!fpga_start) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], fpga_but1};
    end
  end

  assign pressed = ~sync[SYNC_STAGES-1];
`else
  logic unused_but;
  assign unused_but = fpga_but1;
  assign pressed    = 1'b0;
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    reset_next = reset_q;
    case (state)
      HOLD: begin
        reset_next = 1'b0;
        if (pressed) begin
          cnt_next = RELOAD;
        end else if (cnt != 24'd0) begin
          cnt_next = cnt - 24'd1;
        end else begin
          state_next = RUN;
          reset_next = 1'b1;
        end
      end
      default: begin
        reset_next = 1'b1;
        if (pressed) begin
          state_next = HOLD;
          cnt_next   = RELOAD;
          reset_next = 1'b0;
        end
      end
    endcase
  end

  // The start strobe reloads asynchronously and wins over any clock or button activity.
  always_ff @(posedge clk or negedge fpga_start) begin
    if (!fpga_start) begin
      state   <= HOLD;
      cnt     <= RELOAD;
      reset_q <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      reset_q <= reset_next;
    end
  end

  assign reset     = reset_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_reset_gen.sv
`timescale 1ns/1ps
// tb_reset_gen: directed vectors for reset_gen with a short pulse length (10 cycles).
module tb_reset_gen;

  localparam int RC = 10;
`ifdef RESET_BUTTON_EN
  localparam bit BTN = 1'b1;
`else
  localparam bit BTN = 1'b0;
`endif

  typedef struct {
    logic start;
    logic but;
    int   n;
    logic exp_reset;
    logic exp_state;
  } vec_t;

  logic clk        = 1'b0;
  logic fpga_start = 1'b1;
  logic fpga_but1  = 1'b1;
  logic reset;
  logic fsm_state;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  logic [1:0] exp_q[$];

  reset_gen #(
    .RESET_CYCLES(RC),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .fpga_start(fpga_start),
    .fpga_but1 (fpga_but1),
    .reset     (reset),
    .fsm_state (fsm_state)
  );

  // clock: posedges at odd ns, negedges (sampling points) at even ns
  always #1 clk = ~clk;

  task automatic check(input string name, input logic [1:0] exp);
    checks++;
    if ({reset, fsm_state} !== exp) begin
      errors++;
      $display("FAIL %s at %0t: {reset,state} got %b expected %b", name, $time, {reset, fsm_state}, exp);
    end
  endtask

  task automatic add(input logic s, input logic b, input int n, input logic r, input logic st);
    vecs.push_back('{start: s, but: b, n: n, exp_reset: r, exp_state: st});
  endtask

  // Rows whose outcome depends on the button; without it the block just sits in RUN.
  task automatic add_b(input logic s, input logic b, input int n, input logic r, input logic st);
    if (BTN) add(s, b, n, r, st);
    else     add(s, b, n, 1'b1, 1'b0);
  endtask

  task automatic async_pulse(input string name);
    fpga_start = 1'b0;
    #0.2;
    check(name, 2'b01);
    #0.3;
    fpga_start = 1'b1;
  endtask

  initial begin
    // release after async start: RC edges, then RUN
    add(1, 1, RC - 1, 0, 1);
    add(1, 1, 1, 1, 0);
    add(1, 1, 5, 1, 0);
    // press from RUN: reset falls on the 3rd edge
    add_b(1, 0, 2, 1, 0);
    add_b(1, 0, 1, 0, 1);
    add_b(1, 0, 20, 0, 1);
    // release: synced release at edge 2, rise at edge 2+RC
    add_b(1, 1, RC + 1, 0, 1);
    add_b(1, 1, 1, 1, 0);
    // one-cycle press is captured
    add_b(1, 0, 1, 1, 0);
    add_b(1, 1, 2, 0, 1);
    add_b(1, 1, 5, 0, 1);
    // re-press mid-pulse extends the pulse past its original end
    add_b(1, 0, 1, 0, 1);
    add_b(1, 1, 1, 0, 1);
    add_b(1, 1, 3, 0, 1);
    add_b(1, 1, 7, 0, 1);
    add_b(1, 1, 1, 1, 0);
    // start and button together: async dominates, sync preset to released
    add(0, 0, 3, 0, 1);
    add(1, 1, RC - 1, 0, 1);
    add(1, 1, 1, 1, 0);
    // start released while the button is held
    add(0, 1, 2, 0, 1);
    add(1, 0, 4, 0, 1);
    add(1, 1, RC + 1, BTN ? 1'b0 : 1'b1, BTN ? 1'b1 : 1'b0);
    add(1, 1, 1, 1, 0);

    // power-up: reset released before any start
    #2;
    check("powerup_t2", 2'b10);
    repeat (40) @(negedge clk);
    check("powerup_idle", 2'b10);

    async_pulse("async_start");

    foreach (vecs[i]) begin
      fpga_start = vecs[i].start;
      fpga_but1  = vecs[i].but;
      exp_q.push_back({vecs[i].exp_reset, vecs[i].exp_state});
      repeat (vecs[i].n) @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), exp_q.pop_front());
    end

    // async reload mid-pulse restarts the full count
    fpga_start = 1'b1;
    fpga_but1  = 1'b1;
    async_pulse("async_first");
    repeat (4) @(posedge clk);
    @(negedge clk);
    async_pulse("async_mid_pulse");
    repeat (RC - 1) @(posedge clk);
    @(negedge clk);
    check("reload_still_low", 2'b01);
    @(posedge clk);
    @(negedge clk);
    check("reload_release", 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
